control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/ctrl_pkg.sv | 66 ++++++
 rtl/instr_decoder.sv | 64 ++++++
 rtl/control_fsm.sv | 109 ++++++++++
 tb/tb_control_fsm.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control path: FSM states, opcodes,
// ALU function codes and the decoded-instruction record.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BR
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_NOP
  } class_e;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_ALWAYS,
    BR_EQ,
    BR_NE
  } br_e;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_NANDI = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_NOT  = 4'b0100;
  localparam logic [3:0] ALU_NAND = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_ROL  = 4'b1100;
  localparam logic [3:0] ALU_ROR  = 4'b1101;

  typedef struct packed {
    class_e     cls;
    br_e        br;
    logic [3:0] alu_func;
    logic       alu_bin_sel;
    logic       rf_b_sel;
    logic       rf_wrdata_sel;
    logic       lb_trim;
  } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode classifier: instruction class, branch kind and the
// static datapath selects that stay constant for the whole instruction.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [3:0] func_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o     = '0;
    dec_o.cls = CLS_NOP;
    dec_o.br  = BR_NONE;
    case (opcode_i)
      OP_RTYPE: begin
        // unknown funcs still execute; the ALU sees the raw low bits
        dec_o.cls      = CLS_ALU_R;
        dec_o.alu_func = func_i;
      end
      OP_LI, OP_LUI, OP_ADDI: begin
        dec_o.cls         = CLS_ALU_I;
        dec_o.alu_func    = ALU_ADD;
        dec_o.alu_bin_sel = 1'b1;
      end
      OP_NANDI: begin
        dec_o.cls         = CLS_ALU_I;
        dec_o.alu_func    = ALU_NAND;
        dec_o.alu_bin_sel = 1'b1;
      end
      OP_ORI: begin
        dec_o.cls         = CLS_ALU_I;
        dec_o.alu_func    = ALU_OR;
        dec_o.alu_bin_sel = 1'b1;
      end
      OP_LW, OP_LB: begin
        dec_o.cls           = CLS_LOAD;
        dec_o.alu_func      = ALU_ADD;
        dec_o.alu_bin_sel   = 1'b1;
        dec_o.rf_wrdata_sel = 1'b1;
        dec_o.lb_trim       = (opcode_i == OP_LB);
      end
      OP_SW: begin
        dec_o.cls         = CLS_STORE;
        dec_o.alu_func    = ALU_ADD;
        dec_o.alu_bin_sel = 1'b1;
        dec_o.rf_b_sel    = 1'b1;
      end
      OP_B: begin
        dec_o.cls      = CLS_BRANCH;
        dec_o.br       = BR_ALWAYS;
        dec_o.alu_func = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        dec_o.cls      = CLS_BRANCH;
        dec_o.br       = (opcode_i == OP_BEQ) ? BR_EQ : BR_NE;
        dec_o.alu_func = ALU_SUB;
        dec_o.rf_b_sel = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle sequencer: walks each instruction through its state sequence and
// gates the write/load enables; static selects come from instr_decoder.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   S_FETCH  | instruction word being fetched, outputs idle
//   S_DECODE | opcode classified; NOP ends here with PC load
//   S_EXEC   | ALU operation / address calculation
//   S_MEM    | data memory access; sw ends here
//   S_WB     | register-file write-back, PC load
//   S_BR     | branch resolve on Zero, PC load
module control_fsm
  import ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic        PC_Sel,
  output logic        PC_LdEn,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        Mem_WrEn,
  output logic        lb_MEM_trim,
  output logic        Illegal
);

  state_e state_q, state_d;
  dec_t   dec;
  logic   active;
  logic   unused_instr_bits;

  assign unused_instr_bits = ^Instr[25:4];

  instr_decoder u_dec (
    .opcode_i (Instr[31:26]),
    .func_i   (Instr[3:0]),
    .dec_o    (dec)
  );

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (dec.cls == CLS_NOP)         state_d = S_FETCH;
        else if (dec.cls == CLS_BRANCH) state_d = S_BR;
        else                            state_d = S_EXEC;
      end
      S_EXEC: begin
        if (dec.cls == CLS_LOAD || dec.cls == CLS_STORE) state_d = S_MEM;
        else                                              state_d = S_WB;
      end
      S_MEM:    state_d = (dec.cls == CLS_LOAD) ? S_WB : S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Reset gates every output so a reset cycle can never write RF, memory or PC
  assign active = Reset && (state_q != S_FETCH);

  always_comb begin
    PC_Sel        = 1'b0;
    PC_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    Mem_WrEn      = 1'b0;
    Illegal       = 1'b0;
    RF_WrData_sel = active & dec.rf_wrdata_sel;
    RF_B_sel      = active & dec.rf_b_sel;
    ALU_Bin_sel   = active & dec.alu_bin_sel;
    lb_MEM_trim   = active & dec.lb_trim;
    ALU_func      = active ? dec.alu_func : ALU_ADD;
    if (Reset) begin
      case (state_q)
        S_DECODE: begin
          Illegal = (dec.cls == CLS_NOP);
          PC_LdEn = (dec.cls == CLS_NOP);
        end
        S_MEM: begin
          Mem_WrEn = (dec.cls == CLS_STORE);
          PC_LdEn  = (dec.cls == CLS_STORE);
        end
        S_WB: begin
          RF_WrEn = 1'b1;
          PC_LdEn = 1'b1;
        end
        S_BR: begin
          PC_LdEn = 1'b1;
          case (dec.br)
            BR_ALWAYS: PC_Sel = 1'b1;
            BR_EQ:     PC_Sel = Zero;
            BR_NE:     PC_Sel = ~Zero;
            default:   PC_Sel = 1'b0;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed per-cycle vectors for control_fsm; each expected output word is
// written out by hand from the instruction's state sequence.
module tb_control_fsm;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Instr;
  logic        Zero;
  logic        PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic        Mem_WrEn, lb_MEM_trim, Illegal;

  int n_vec  = 0;
  int n_miss = 0;

  control_fsm dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Instr         (Instr),
    .Zero          (Zero),
    .PC_Sel        (PC_Sel),
    .PC_LdEn       (PC_LdEn),
    .RF_WrEn       (RF_WrEn),
    .RF_WrData_sel (RF_WrData_sel),
    .RF_B_sel      (RF_B_sel),
    .ALU_Bin_sel   (ALU_Bin_sel),
    .ALU_func      (ALU_func),
    .Mem_WrEn      (Mem_WrEn),
    .lb_MEM_trim   (lb_MEM_trim),
    .Illegal       (Illegal)
  );

  always #5 Clk = ~Clk;

  // {PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel, ALU_func, Mem_WrEn, lb_MEM_trim, Illegal}
  logic [12:0] obs;
  assign obs = {PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel,
                ALU_func, Mem_WrEn, lb_MEM_trim, Illegal};

  function automatic logic [12:0] ov(input logic pcsel, input logic ld, input logic rfw,
                                     input logic wds, input logic bsel, input logic bin,
                                     input logic [3:0] fn, input logic mw, input logic trim,
                                     input logic ill);
    return {pcsel, ld, rfw, wds, bsel, bin, fn, mw, trim, ill};
  endfunction

  localparam logic [12:0] Z = 13'h0;

  task automatic check_out(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // one clock cycle: drive, sample mid-cycle at negedge, advance past posedge
  task automatic cyc(input string tag, input logic [31:0] ins, input logic z,
                     input logic rst_n, input logic [12:0] exp);
    Instr = ins;
    Zero  = z;
    Reset = rst_n;
    @(negedge Clk);
    check_out(tag, obs, exp);
    @(posedge Clk);
    #1;
  endtask

  localparam logic [31:0] I_RADD  = 32'h8000_0030;
  localparam logic [31:0] I_RNAND = 32'h8000_0035;
  localparam logic [31:0] I_RUNK  = 32'h8000_003F;
  localparam logic [31:0] I_ADDI  = 32'hC000_0000;
  localparam logic [31:0] I_NANDI = 32'hC800_0000;
  localparam logic [31:0] I_ORI   = 32'hCC00_0000;
  localparam logic [31:0] I_LI    = 32'hE000_0000;
  localparam logic [31:0] I_LB    = 32'h0C00_0000;
  localparam logic [31:0] I_LW    = 32'h3C00_0000;
  localparam logic [31:0] I_SW    = 32'h7C00_0000;
  localparam logic [31:0] I_BEQ   = 32'h0000_0000;
  localparam logic [31:0] I_BNE   = 32'h0400_0000;
  localparam logic [31:0] I_B     = 32'hFC00_0000;
  localparam logic [31:0] I_ILL   = 32'h5400_0000;

  initial begin
    Reset = 1'b0;
    Instr = I_SW;
    Zero  = 1'b0;

    cyc("rst0", I_SW, 0, 0, Z);
    cyc("rst1", I_SW, 1, 0, Z);

    cyc("radd_f", I_RADD, 0, 1, Z);
    cyc("radd_d", I_RADD, 0, 1, Z);
    cyc("radd_e", I_RADD, 0, 1, Z);
    cyc("radd_w", I_RADD, 0, 1, ov(0,1,1,0,0,0,4'h0,0,0,0));

    cyc("rnand_f", I_RNAND, 1, 1, Z);
    cyc("rnand_d", I_RNAND, 1, 1, ov(0,0,0,0,0,0,4'h5,0,0,0));
    cyc("rnand_e", I_RNAND, 1, 1, ov(0,0,0,0,0,0,4'h5,0,0,0));
    cyc("rnand_w", I_RNAND, 1, 1, ov(0,1,1,0,0,0,4'h5,0,0,0));

    cyc("runk_f", I_RUNK, 0, 1, Z);
    cyc("runk_d", I_RUNK, 0, 1, ov(0,0,0,0,0,0,4'hF,0,0,0));
    cyc("runk_e", I_RUNK, 0, 1, ov(0,0,0,0,0,0,4'hF,0,0,0));
    cyc("runk_w", I_RUNK, 0, 1, ov(0,1,1,0,0,0,4'hF,0,0,0));

    cyc("addi_f", I_ADDI, 0, 1, Z);
    cyc("addi_d", I_ADDI, 0, 1, ov(0,0,0,0,0,1,4'h0,0,0,0));
    cyc("addi_e", I_ADDI, 0, 1, ov(0,0,0,0,0,1,4'h0,0,0,0));
    cyc("addi_w", I_ADDI, 0, 1, ov(0,1,1,0,0,1,4'h0,0,0,0));

    cyc("nandi_f", I_NANDI, 0, 1, Z);
    cyc("nandi_d", I_NANDI, 0, 1, ov(0,0,0,0,0,1,4'h5,0,0,0));
    cyc("nandi_e", I_NANDI, 0, 1, ov(0,0,0,0,0,1,4'h5,0,0,0));
    cyc("nandi_w", I_NANDI, 0, 1, ov(0,1,1,0,0,1,4'h5,0,0,0));

    cyc("ori_f", I_ORI, 0, 1, Z);
    cyc("ori_d", I_ORI, 0, 1, ov(0,0,0,0,0,1,4'h3,0,0,0));
    cyc("ori_e", I_ORI, 0, 1, ov(0,0,0,0,0,1,4'h3,0,0,0));
    cyc("ori_w", I_ORI, 0, 1, ov(0,1,1,0,0,1,4'h3,0,0,0));

    cyc("li_f", I_LI, 0, 1, Z);
    cyc("li_d", I_LI, 0, 1, ov(0,0,0,0,0,1,4'h0,0,0,0));
    cyc("li_e", I_LI, 0, 1, ov(0,0,0,0,0,1,4'h0,0,0,0));
    cyc("li_w", I_LI, 0, 1, ov(0,1,1,0,0,1,4'h0,0,0,0));

    cyc("lb_f", I_LB, 0, 1, Z);
    cyc("lb_d", I_LB, 0, 1, ov(0,0,0,1,0,1,4'h0,0,1,0));
    cyc("lb_e", I_LB, 0, 1, ov(0,0,0,1,0,1,4'h0,0,1,0));
    cyc("lb_m", I_LB, 0, 1, ov(0,0,0,1,0,1,4'h0,0,1,0));
    cyc("lb_w", I_LB, 0, 1, ov(0,1,1,1,0,1,4'h0,0,1,0));

    cyc("lw_f", I_LW, 0, 1, Z);
    cyc("lw_d", I_LW, 0, 1, ov(0,0,0,1,0,1,4'h0,0,0,0));
    cyc("lw_e", I_LW, 0, 1, ov(0,0,0,1,0,1,4'h0,0,0,0));
    cyc("lw_m", I_LW, 0, 1, ov(0,0,0,1,0,1,4'h0,0,0,0));
    cyc("lw_w", I_LW, 0, 1, ov(0,1,1,1,0,1,4'h0,0,0,0));

    cyc("sw_f", I_SW, 0, 1, Z);
    cyc("sw_d", I_SW, 0, 1, ov(0,0,0,0,1,1,4'h0,0,0,0));
    cyc("sw_e", I_SW, 0, 1, ov(0,0,0,0,1,1,4'h0,0,0,0));
    cyc("sw_m", I_SW, 0, 1, ov(0,1,0,0,1,1,4'h0,1,0,0));

    cyc("beq1_f", I_BEQ, 0, 1, Z);
    cyc("beq1_d", I_BEQ, 0, 1, ov(0,0,0,0,1,0,4'h1,0,0,0));
    cyc("beq1_br", I_BEQ, 1, 1, ov(1,1,0,0,1,0,4'h1,0,0,0));

    cyc("beq0_f", I_BEQ, 1, 1, Z);
    cyc("beq0_d", I_BEQ, 1, 1, ov(0,0,0,0,1,0,4'h1,0,0,0));
    cyc("beq0_br", I_BEQ, 0, 1, ov(0,1,0,0,1,0,4'h1,0,0,0));

    cyc("bne1_f", I_BNE, 0, 1, Z);
    cyc("bne1_d", I_BNE, 0, 1, ov(0,0,0,0,1,0,4'h1,0,0,0));
    cyc("bne1_br", I_BNE, 1, 1, ov(0,1,0,0,1,0,4'h1,0,0,0));

    cyc("bne0_f", I_BNE, 1, 1, Z);
    cyc("bne0_d", I_BNE, 1, 1, ov(0,0,0,0,1,0,4'h1,0,0,0));
    cyc("bne0_br", I_BNE, 0, 1, ov(1,1,0,0,1,0,4'h1,0,0,0));

    cyc("b_f", I_B, 0, 1, Z);
    cyc("b_d", I_B, 0, 1, Z);
    cyc("b_br", I_B, 0, 1, ov(1,1,0,0,0,0,4'h0,0,0,0));

    cyc("ill_f", I_ILL, 0, 1, Z);
    cyc("ill_d", I_ILL, 0, 1, ov(0,1,0,0,0,0,4'h0,0,0,1));

    cyc("lwrst_f", I_LW, 0, 1, Z);
    cyc("lwrst_d", I_LW, 0, 1, ov(0,0,0,1,0,1,4'h0,0,0,0));
    cyc("lwrst_e", I_LW, 0, 0, Z);
    cyc("lwrst_r1", I_LW, 0, 0, Z);
    cyc("lwrst_r2", I_LW, 0, 0, Z);

    cyc("post_f", I_ADDI, 0, 1, Z);
    cyc("post_d", I_ADDI, 0, 1, ov(0,0,0,0,0,1,4'h0,0,0,0));
    cyc("post_e", I_ADDI, 0, 1, ov(0,0,0,0,0,1,4'h0,0,0,0));
    cyc("post_w", I_ADDI, 0, 1, ov(0,1,1,0,0,1,4'h0,0,0,0));
    cyc("post_f2", I_SW, 0, 1, Z);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
